// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: five-digit multiplexed seven-segment scanner.
// Snapshots the converter's BCD nibbles on a load strobe and applies them
// only at a frame boundary, so a frame never shows a mix of old and new digits.
// Segments {g,f,e,d,c,b,a} and digit enables are active-low. Nibble 15 is blank.
// Optional build macro LZB_EN enables leading-zero blanking on digits D5..D2.
module bcd_seg_scanner #(
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D5,
    input  logic [3:0] D4,
    input  logic [3:0] D3,
    input  logic [3:0] D2,
    input  logic [3:0] D1,
    input  logic       load,
    output logic [4:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PCNT_MAX  = PW'(TICK_DIV - 1);
    localparam logic [2:0]      IDX_LAST  = 3'd4;
    localparam logic [19:0]     ALL_BLANK = 20'hFFFFF;

    // Active-low {g,f,e,d,c,b,a} pattern for one nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            4'd15:   p = 7'h7F;
            default: p = 7'h3F;   // 10..14 shown as a dash
        endcase
        return p;
    endfunction

`ifdef LZB_EN
    // A zero at position k (k >= 1) is blanked when every higher digit is 0
    // or the blank code; position 0 always shows its value.
    function automatic logic lzb_blank(input logic [19:0] sh, input logic [2:0] k);
        logic       res;
        logic [3:0] dj;
        res = (k != 3'd0);
        for (int j = 0; j < 5; j++) begin
            dj = sh[j*4 +: 4];
            if (j == int'(k)) begin
                if (dj != 4'h0) res = 1'b0;
                else            res = res;
            end else if (j > int'(k)) begin
                if ((dj != 4'h0) && (dj != 4'hF)) res = 1'b0;
                else                              res = res;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`endif

    logic [PW-1:0] pcnt_q,       pcnt_d;
    logic [2:0]    idx_q,        idx_d;
    logic          pending_q,    pending_d;
    logic [19:0]   staging_q,    staging_d;
    logic [19:0]   shadow_q,     shadow_d;
    logic [4:0]    an_q,         an_d;
    logic [6:0]    seg_q,        seg_d;
    logic          frame_done_q, frame_done_d;

    logic          tick_s;
    logic          boundary_s;
    logic [19:0]   din_s;
    logic [3:0]    digit_s;
    logic          blank_s;

    assign din_s = {D5, D4, D3, D2, D1};

    // Prescaler and digit index; a boundary is a tick that wraps idx to 0.
    always_comb begin
        tick_s = (pcnt_q == PCNT_MAX);
        if (tick_s) begin
            pcnt_d = '0;
            if (idx_q == IDX_LAST) idx_d = 3'd0;
            else                   idx_d = idx_q + 3'd1;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
            idx_d  = idx_q;
        end
        boundary_s = tick_s && (idx_d == 3'd0);
    end

    // Staging capture on load; shadow only updates at frame boundaries.
    always_comb begin
        if (load) staging_d = din_s;
        else      staging_d = staging_q;

        // A load landing on a boundary goes straight to the shadow, so
        // nothing is left pending.
        if (boundary_s)  pending_d = 1'b0;
        else if (load)   pending_d = 1'b1;
        else             pending_d = pending_q;

        if (boundary_s && load)           shadow_d = din_s;
        else if (boundary_s && pending_q) shadow_d = staging_q;
        else                              shadow_d = shadow_q;
    end

    // Next digit enable and segment pattern, taken from the post-update shadow.
    always_comb begin
        case (idx_d)
            3'd0:    digit_s = shadow_d[3:0];
            3'd1:    digit_s = shadow_d[7:4];
            3'd2:    digit_s = shadow_d[11:8];
            3'd3:    digit_s = shadow_d[15:12];
            3'd4:    digit_s = shadow_d[19:16];
            default: digit_s = 4'hF;
        endcase
`ifdef LZB_EN
        blank_s = lzb_blank(shadow_d, idx_d);
`else
        blank_s = 1'b0;
`endif
        if (tick_s) begin
            an_d = ~(5'b00001 << idx_d);
            if (blank_s) seg_d = 7'h7F;
            else         seg_d = seg_decode(digit_s);
        end else begin
            an_d  = an_q;
            seg_d = seg_q;
        end
        frame_done_d = boundary_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= IDX_LAST;
            pending_q    <= 1'b0;
            staging_q    <= ALL_BLANK;
            shadow_q     <= ALL_BLANK;
            an_q         <= 5'b11111;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner with TICK_DIV=4.
// A table of load records is played one frame at a time; each frame's
// expected {an, seg} per slot is queued at frame start and popped per slot.
module tb_bcd_seg_scanner;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] d5, d4, d3, d2, d1;
    logic       load;
    logic [4:0] an;
    logic [6:0] seg;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        int          pre_at;
        logic [19:0] pre;
        int          load_at;
        logic [19:0] digs;
        logic [34:0] segs;   // {slot4, slot3, slot2, slot1, slot0}
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    localparam logic [34:0] ALL_BLANK_SEGS = {5{7'h7F}};

    bcd_seg_scanner #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D5         (d5),
        .D4         (d4),
        .D3         (d3),
        .D2         (d2),
        .D1         (d1),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // From a reset-release negedge: blank for TD-1 cycles, then digit 0 with frame_done.
    task automatic post_reset_check();
        for (int i = 1; i < TD; i++) begin
            @(negedge clk);
            chk("pre_tick_an", {27'd0, an}, 32'h1F);
            chk("pre_tick_seg", {25'd0, seg}, 32'h7F);
            chk("pre_tick_fd", {31'd0, frame_done}, 32'd0);
        end
        @(negedge clk);
        chk("first_tick_fd", {31'd0, frame_done}, 32'd1);
        chk("first_tick_an", {27'd0, an}, 32'h1E);
        chk("first_tick_seg", {25'd0, seg}, 32'h7F);
    endtask

    // Called at the negedge where frame_done is seen; checks one whole frame
    // and optionally issues loads at given cycle offsets within it.
    task automatic check_frame(input logic [34:0] exp_segs, input int pre_at,
                               input logic [19:0] pre, input int load_at,
                               input logic [19:0] digs);
        exp_t e;
        exp_t cur_e;
        int   fd_cnt;
        for (int k = 0; k < 5; k++) begin
            e.an  = 5'b11111 ^ (5'b00001 << k);
            e.seg = exp_segs[k*7 +: 7];
            sb_q.push_back(e);
        end
        cur_e  = '1;
        fd_cnt = 0;
        for (int i = 0; i < 5*TD; i++) begin
            if (i == pre_at) begin
                {d5, d4, d3, d2, d1} = pre;
                load = 1'b1;
            end else if (i == load_at) begin
                {d5, d4, d3, d2, d1} = digs;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ((i % TD) == 0) begin
                if (sb_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    cur_e = sb_q.pop_front();
                end
            end
            chk("slot_an", {27'd0, an}, {27'd0, cur_e.an});
            chk("slot_seg", {25'd0, seg}, {25'd0, cur_e.seg});
            if (frame_done === 1'b1) fd_cnt++;
            @(negedge clk);
        end
        chk("frame_done_count", fd_cnt, 32'd1);
        chk("frame_period", {31'd0, frame_done}, 32'd1);
    endtask

    initial begin
        logic [34:0] cur;

        // Table: loads mid-frame, two loads in one frame, codes 10..15,
        // loads coinciding with the boundary, and leading-zero cases.
        vecs[0] = '{-1, 20'h0, 6,  20'h01234, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{2, 20'h12345, 13, 20'h99999, {5{7'h10}}};
        vecs[2] = '{-1, 20'h0, 6,  20'hABCEF, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F}};
        vecs[3] = '{-1, 20'h0, 19, 20'h00100, {7'h40, 7'h40, 7'h79, 7'h40, 7'h40}};
        vecs[4] = '{-1, 20'h0, 6,  20'h00000, {5{7'h40}}};
        vecs[5] = '{-1, 20'h0, 9,  20'h56780, {7'h12, 7'h02, 7'h78, 7'h00, 7'h40}};
        vecs[6] = '{-1, 20'h0, 19, 20'hF0030, {7'h7F, 7'h40, 7'h40, 7'h30, 7'h40}};
`ifdef LZB_EN
        vecs[0].segs = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
        vecs[3].segs = {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40};
        vecs[4].segs = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
        vecs[6].segs = {7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40};
`endif

        rst_n = 1'b0;
        load  = 1'b0;
        {d5, d4, d3, d2, d1} = 20'h00000;
        repeat (3) @(negedge clk);
        chk("reset_an", {27'd0, an}, 32'h1F);
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        post_reset_check();

        cur = ALL_BLANK_SEGS;
        for (int r = 0; r < 7; r++) begin
            check_frame(cur, vecs[r].pre_at, vecs[r].pre, vecs[r].load_at, vecs[r].digs);
            if (vecs[r].load_at == 5*TD - 1) begin
                chk("pending_after_coincident", {31'd0, dut.pending_q}, 32'd0);
            end
            cur = vecs[r].segs;
        end
        check_frame(cur, -1, 20'h0, -1, 20'h0);
        check_frame(cur, -1, 20'h0, -1, 20'h0);

        // Load mid-frame, then reset before the boundary applies it.
        {d5, d4, d3, d2, d1} = 20'h13579;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_an", {27'd0, an}, 32'h1F);
        chk("async_reset_seg", {25'd0, seg}, 32'h7F);
        chk("async_reset_fd", {31'd0, frame_done}, 32'd0);
        chk("async_reset_pending", {31'd0, dut.pending_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset_check();
        check_frame(ALL_BLANK_SEGS, -1, 20'h0, -1, 20'h0);
        check_frame(ALL_BLANK_SEGS, -1, 20'h0, -1, 20'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
